// File: rtl/mul_iter_pkg.sv
// Shared types and constants for the iterative EX-stage multiplier.
// Holds the FSM state encoding and the decode constants that raise valid_i.
package mul_iter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // RV32M MUL decode: OP major opcode with the MULDIV funct7 and funct3=000
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [2:0] FUNCT3_MUL    = 3'b000;

endpackage

// File: rtl/mul_iter_if.sv
// Request/response bundle between the EX stage and the iterative multiplier.
// A request transfers on a rising edge where valid_i && ready_o (and no flush_i);
// a result transfers on a rising edge where valid_o && ready_i. Each valid is held
// by its producer until the matching ready is seen; busy_o feeds the hazard stall.
interface mul_iter_if #(
  parameter int WIDTH = 32
);
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic             busy_o;

  modport master (
    output flush_i, valid_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, data_o, busy_o
  );

  modport slave (
    input  flush_i, valid_i, a_i, b_i, ready_i,
    output ready_o, valid_o, data_o, busy_o
  );
endinterface

// File: rtl/mul_iter_step.sv
// One shift-add iteration: adds a_reg times a BITS_PER_CYCLE-wide multiplier slice
// to the accumulator, truncated to WIDTH bits.
module mul_iter_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0]          acc,
  input  logic [WIDTH-1:0]          a_reg,
  input  logic [BITS_PER_CYCLE-1:0] slice,
  output logic [WIDTH-1:0]          acc_next
);

  logic [WIDTH-1:0] partial;

  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (slice[i]) partial = partial + (a_reg << i);
    end
    acc_next = acc + partial;
  end

endmodule

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier for EX; low WIDTH bits of the product are the same
// for signed and unsigned operands, so no sign handling is needed.
module mul_iter
  import mul_iter_pkg::*;
#(
  parameter int WIDTH          = XLEN,
  parameter int BITS_PER_CYCLE = 1,
  parameter bit EARLY_EXIT     = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  mul_iter_if.slave  bus,
  output state_t     state_o
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    count;
  logic             valid_q;
  logic             busy_q;
  logic             ready_q;
  logic             last_step;

  mul_iter_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc      (acc),
    .a_reg    (a_reg),
    .slice    (b_reg[BITS_PER_CYCLE-1:0]),
    .acc_next (acc_next)
  );

  // Early exit looks at b_reg after this cycle's shift: nothing left to add.
  assign last_step = (count == LAST) ||
                     (EARLY_EXIT && ((b_reg >> BITS_PER_CYCLE) == '0));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      acc     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      count   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else if (bus.flush_i) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            a_reg   <= bus.a_i;
            b_reg   <= bus.b_i;
            acc     <= '0;
            count   <= '0;
            state   <= BUSY;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          a_reg <= a_reg << BITS_PER_CYCLE;
          b_reg <= b_reg >> BITS_PER_CYCLE;
          count <= count + 1'b1;
          if (last_step) begin
            state   <= DONE;
            data_q  <= acc_next;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.ready_i) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.busy_o  = busy_q;
  assign bus.ready_o = ready_q;
  assign bus.data_o  = data_q;
  assign state_o     = state;

endmodule

// File: tb/tb_mul_iter.sv
// Directed bench for mul_iter: three configurations (full run, early exit, 4 bits/cycle)
// share the stimulus; sel picks which instance is driven and observed.
module tb_mul_iter;
  import mul_iter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          sel = 0;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic        obs_valid, obs_ready, obs_busy;
  logic [31:0] obs_data;
  state_t      obs_state;
  state_t      st0, st1, st2;

  always #5 clk = ~clk;

  mul_iter_if #(.WIDTH(32)) if0 ();
  mul_iter_if #(.WIDTH(32)) if1 ();
  mul_iter_if #(.WIDTH(32)) if2 ();

  assign if0.flush_i = flush && (sel == 0);
  assign if0.valid_i = valid && (sel == 0);
  assign if0.ready_i = ready && (sel == 0);
  assign if0.a_i     = a;
  assign if0.b_i     = b;
  assign if1.flush_i = flush && (sel == 1);
  assign if1.valid_i = valid && (sel == 1);
  assign if1.ready_i = ready && (sel == 1);
  assign if1.a_i     = a;
  assign if1.b_i     = b;
  assign if2.flush_i = flush && (sel == 2);
  assign if2.valid_i = valid && (sel == 2);
  assign if2.ready_i = ready && (sel == 2);
  assign if2.a_i     = a;
  assign if2.b_i     = b;

  mul_iter #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_EXIT(1'b0)) u_full (
    .clk_i(clk), .rst_i(rst), .bus(if0), .state_o(st0));
  mul_iter #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_EXIT(1'b1)) u_early (
    .clk_i(clk), .rst_i(rst), .bus(if1), .state_o(st1));
  mul_iter #(.WIDTH(32), .BITS_PER_CYCLE(4), .EARLY_EXIT(1'b0)) u_quad (
    .clk_i(clk), .rst_i(rst), .bus(if2), .state_o(st2));

  always_comb begin
    obs_valid = if0.valid_o;
    obs_ready = if0.ready_o;
    obs_busy  = if0.busy_o;
    obs_data  = if0.data_o;
    obs_state = st0;
    case (sel)
      1: begin
        obs_valid = if1.valid_o; obs_ready = if1.ready_o; obs_busy = if1.busy_o;
        obs_data  = if1.data_o;  obs_state = st1;
      end
      2: begin
        obs_valid = if2.valid_o; obs_ready = if2.ready_o; obs_busy = if2.busy_o;
        obs_data  = if2.data_o;  obs_state = st2;
      end
      default: ;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check1({tag, "_valid"}, obs_valid, 1'b0);
    check1({tag, "_busy"},  obs_busy,  1'b0);
    check1({tag, "_ready"}, obs_ready, 1'b1);
    check({tag, "_state"}, 32'(obs_state), 32'(IDLE));
  endtask

  // Issue one request and wait (bounded) for valid_o; poke pulses stray valid_i while busy.
  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input int exp_lat, input logic [31:0] exp_data, input logic poke);
    int cyc;
    a = av; b = bv; valid = 1'b1;
    check1({tag, "_ready_before"}, obs_ready, 1'b1);
    step();
    valid = 1'b0;
    a = 32'h1; b = 32'h1;
    cyc = 1;
    check1({tag, "_busy_after_accept"}, obs_busy, 1'b1);
    while (!obs_valid && cyc < 100) begin
      valid = poke && cyc[0];
      step();
      cyc++;
    end
    valid = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_data"}, obs_data, exp_data);
    check1({tag, "_done_busy"}, obs_busy, 1'b1);
    check1({tag, "_done_ready"}, obs_ready, 1'b0);
  endtask

  task automatic consume(input string tag);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check_idle(tag);
  endtask

  initial begin
    #1;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      check_idle("reset");
      check("reset_data", obs_data, 32'h0);
    end
    step();

    // full 32-step run, then backpressure for a few cycles
    sel = 0;
    run("full_7x6", 32'd7, 32'd6, 33, 32'd42, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check1("full_hold_valid", obs_valid, 1'b1);
      check("full_hold_data", obs_data, 32'd42);
    end
    consume("full_consume");

    // early exit with wrapping products and zero multiplier
    sel = 1;
    run("ee_neg1x3", 32'hFFFF_FFFF, 32'd3, 3, 32'hFFFF_FFFD, 1'b0);
    consume("ee_neg1x3_consume");
    run("ee_wrap", 32'h8000_0000, 32'd2, 3, 32'h0, 1'b0);
    consume("ee_wrap_consume");
    run("ee_bzero", 32'd9, 32'd0, 2, 32'h0, 1'b0);
    consume("ee_bzero_consume");

    // stray valid_i during BUSY and DONE, ready_i low for 10 cycles
    run("bp_12345x100", 32'd12345, 32'd100, 8, 32'd1234500, 1'b1);
    for (int i = 0; i < 10; i++) begin
      valid = i[0];
      a = 32'd2; b = 32'd2;
      step();
      check1("bp_hold_valid", obs_valid, 1'b1);
      check("bp_hold_data", obs_data, 32'd1234500);
    end
    valid = 1'b0;
    consume("bp_consume");
    step();
    check_idle("bp_no_stray_accept");

    // flush on the 5th BUSY cycle, with a competing valid_i that must be ignored
    sel = 0;
    a = 32'd3; b = 32'hFFFF_FFFF; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("flush_pre_state", 32'(obs_state), 32'(BUSY));
    flush = 1'b1; valid = 1'b1; a = 32'd11; b = 32'd11;
    step();
    flush = 1'b0; valid = 1'b0;
    check_idle("flush");
    run("after_flush_5x5", 32'd5, 32'd5, 33, 32'd25, 1'b0);
    consume("after_flush_consume");

    // reset in the middle of a run
    sel = 1;
    a = 32'd3; b = 32'hFFFF_FFFF; valid = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    step();
    check_idle("mid_reset");
    check("mid_reset_data", obs_data, 32'h0);
    sel = 0;
    #0;
    check("mid_reset_full_data", obs_data, 32'h0);
    rst = 1'b1;
    step();

    // four bits per cycle, plus a full-overflow product
    sel = 2;
    run("quad_1234x10", 32'h1234, 32'h10, 9, 32'h0001_2340, 1'b0);
    consume("quad_consume");
    run("quad_ovf", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 32'h0000_0001, 1'b0);
    consume("quad_ovf_consume");

    // no early exit on the full-run instance even with b_i = 0
    sel = 0;
    run("full_bzero", 32'd5, 32'd0, 33, 32'h0, 1'b0);
    consume("full_bzero_consume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
